// File: rtl/tb_status_periph.sv
// Stdout/status pseudo peripheral: OBI slave with a print FIFO, a pass/fail/exit mailbox
// and a read-only cycle counter. Mailbox writes wait until all queued characters drain.
module tb_status_periph #(
    parameter logic [31:0] PRINT_ADDR  = 32'h1000_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h2000_0000,
    parameter logic [31:0] EXIT_ADDR   = 32'h2000_0004,
    parameter logic [31:0] CYCLE_ADDR  = 32'h1500_0000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        print_valid_o,
    output logic [31:0] print_wdata_o,
    input  logic        print_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] PassValue = 32'd123456789;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0] cycle_q, cycle_d;
    logic        rvalid_q, rvalid_d, err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        passed_q, passed_d, failed_q, failed_d, exit_q, exit_d;
    logic [31:0] exit_value_q, exit_value_d;

    logic hit_print, hit_status, hit_exit, hit_cycle, unmapped;
    logic empty, full, pending, gnt, push, pop;
    logic unused_bits;

    assign unused_bits = ^{addr_i[1:0], be_i[3:1]};

    assign hit_print  = addr_i[31:2] == PRINT_ADDR[31:2];
    assign hit_status = addr_i[31:2] == STATUS_ADDR[31:2];
    assign hit_exit   = addr_i[31:2] == EXIT_ADDR[31:2];
    assign hit_cycle  = addr_i[31:2] == CYCLE_ADDR[31:2];
    assign unmapped   = !(hit_print || hit_status || hit_exit || hit_cycle);

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pending = passed_q || failed_q || exit_q;

    always_comb begin
        gnt = 1'b0;
        if (req_i) begin
            if (hit_print && we_i && be_i[0]) begin
                gnt = !full;
            end else if ((hit_status || hit_exit) && we_i) begin
                gnt = empty && !pending;
            end else begin
                gnt = 1'b1;
            end
        end
    end

    assign push = gnt && hit_print && we_i && be_i[0];
    assign pop  = !empty && print_ready_i;

    always_comb begin
        wptr_d       = wptr_q + (AW + 1)'(push);
        rptr_d       = rptr_q + (AW + 1)'(pop);
        cycle_d      = cycle_q + 32'd1;
        rvalid_d     = gnt;
        err_d        = gnt && (unmapped || (hit_cycle && we_i));
        rdata_d      = (gnt && hit_cycle && !we_i) ? cycle_q : 32'd0;
        passed_d     = gnt && hit_status && we_i && (wdata_i == PassValue);
        failed_d     = gnt && hit_status && we_i && (wdata_i != PassValue);
        exit_d       = gnt && hit_exit && we_i;
        exit_value_d = exit_d ? wdata_i : exit_value_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cycle_q      <= '0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_q       <= 1'b0;
            exit_value_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cycle_q      <= cycle_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            exit_q       <= exit_d;
            exit_value_q <= exit_value_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i[7:0];
        end
    end

    assign gnt_o          = gnt;
    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign err_o          = err_q;
    assign print_valid_o  = !empty;
    assign print_wdata_o  = empty ? 32'd0 : {24'd0, mem_q[rptr_q[AW-1:0]]};
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_q;
    assign exit_value_o   = exit_value_q;
endmodule

// File: tb/tb_tb_status_periph.sv
// Self-checking bench for tb_status_periph: response and character scoreboards fed at grant
// time, plus per-scenario checks on grants and mailbox pulses.
module tb_tb_status_periph;
    localparam logic [31:0] PRINT_A  = 32'h1000_0000;
    localparam logic [31:0] STATUS_A = 32'h2000_0000;
    localparam logic [31:0] EXIT_A   = 32'h2000_0004;
    localparam logic [31:0] CYCLE_A  = 32'h1500_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        print_valid_o;
    logic [31:0] print_wdata_o;
    logic        print_ready_i = 1'b0;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] exit_value_o;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_chars[$];
    logic [32:0] exp_resp[$];
    logic [31:0] model_cyc;
    logic [32:0] mon_r;
    logic [7:0]  mon_c;

    always #5 clk = ~clk;

    tb_status_periph dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .wdata_i        (wdata_i),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .print_valid_o  (print_valid_o),
        .print_wdata_o  (print_wdata_o),
        .print_ready_i  (print_ready_i),
        .tests_passed_o (tests_passed_o),
        .tests_failed_o (tests_failed_o),
        .exit_valid_o   (exit_valid_o),
        .exit_value_o   (exit_value_o)
    );

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) model_cyc <= '0;
        else         model_cyc <= model_cyc + 32'd1;
    end

    // Scoreboard consumers: responses and popped characters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_ni) begin
            checks++;
            if (rvalid_o === 1'b1) begin
                if (exp_resp.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: err=%0b rdata=%h, required no response",
                             err_o, rdata_o);
                end else begin
                    mon_r = exp_resp.pop_front();
                    if ({err_o, rdata_o} !== mon_r) begin
                        errors++;
                        $display("FAIL resp_value: err=%0b rdata=%h, required err=%0b rdata=%h",
                                 err_o, rdata_o, mon_r[32], mon_r[31:0]);
                    end
                end
            end else if (err_o !== 1'b0 || rdata_o !== 32'd0) begin
                errors++;
                $display("FAIL resp_idle: err=%0b rdata=%h, required 0 without rvalid",
                         err_o, rdata_o);
            end
            if (print_valid_o === 1'b1 && print_ready_i) begin
                checks++;
                if (exp_chars.size() == 0) begin
                    errors++;
                    $display("FAIL char_unexpected: got %h, required none", print_wdata_o);
                end else begin
                    mon_c = exp_chars.pop_front();
                    if (print_wdata_o !== {24'd0, mon_c}) begin
                        errors++;
                        $display("FAIL char_value: got %h, required %h", print_wdata_o,
                                 {24'd0, mon_c});
                    end
                end
            end
        end
    end

    function automatic logic [32:0] exp_of(input logic w, input logic [31:0] a,
                                           input logic [31:0] cyc);
        logic [31:0] word;
        word = {a[31:2], 2'b00};
        if (word == CYCLE_A) return w ? {1'b1, 32'd0} : {1'b0, cyc};
        if (word == PRINT_A || word == STATUS_A || word == EXIT_A) return 33'd0;
        return {1'b1, 32'd0};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one request until granted or budget expires; waited = -1 on expiry.
    task automatic bus_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int budget, output int waited);
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; be_i = be;
        waited = 0;
        #1;
        while (gnt_o !== 1'b1 && waited < budget) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (gnt_o === 1'b1) begin
            exp_resp.push_back(exp_of(w, a, model_cyc));
            if (w && {a[31:2], 2'b00} == PRINT_A && be[0]) exp_chars.push_back(d[7:0]);
        end else begin
            waited = -1;
        end
        @(posedge clk);
        #1;
        req_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        step(3);
        checks++;
        if ({gnt_o, rvalid_o, rdata_o, err_o, print_valid_o, print_wdata_o, tests_passed_o,
             tests_failed_o, exit_valid_o, exit_value_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero, required all 0");
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_print_burst;
        logic [7:0] msg [3];
        int w;
        msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
        print_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_req(1'b1, PRINT_A, {24'hABCDEF, msg[i]}, 4'hF, 0, w);
            checks++;
            if (w !== 0) begin
                errors++;
                $display("FAIL burst_grant: char %0d waited %0d, required 0", i, w);
            end
        end
        step(3);
        checks++;
        if (exp_chars.size() != 0 || exp_resp.size() != 0) begin
            errors++;
            $display("FAIL burst_drain: %0d chars %0d resps left, required 0",
                     exp_chars.size(), exp_resp.size());
        end
    endtask

    task automatic test_fifo_full;
        int w;
        int n;
        print_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_req(1'b1, PRINT_A, 32'h41 + i, 4'h1, 0, w);
            checks++;
            if (w !== 0) begin
                errors++;
                $display("FAIL full_fill: write %0d waited %0d, required 0", i, w);
            end
        end
        bus_req(1'b1, PRINT_A, 32'h49, 4'h1, 3, w);
        checks++;
        if (w !== -1) begin
            errors++;
            $display("FAIL full_block: 9th write waited %0d, required no grant", w);
        end
        print_ready_i = 1'b1;
        bus_req(1'b1, PRINT_A, 32'h49, 4'h1, 5, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL full_release: 9th write waited %0d, required 1", w);
        end
        n = 0;
        while (print_valid_o === 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (print_valid_o !== 1'b0 || exp_chars.size() != 0) begin
            errors++;
            $display("FAIL full_drain: valid=%0b left=%0d, required 0 and 0", print_valid_o,
                     exp_chars.size());
        end
    endtask

    task automatic test_exit;
        int w;
        bus_req(1'b1, EXIT_A, 32'h5A, 4'hF, 0, w);
        #1;
        checks++;
        if (w !== 0 || exit_valid_o !== 1'b1 || exit_value_o !== 32'h5A ||
            tests_passed_o !== 1'b0 || tests_failed_o !== 1'b0) begin
            errors++;
            $display("FAIL exit_pulse: wait=%0d valid=%0b value=%h, required 0 1 0000005a",
                     w, exit_valid_o, exit_value_o);
        end
        step(1);
        checks++;
        if (exit_valid_o !== 1'b0 || exit_value_o !== 32'h5A) begin
            errors++;
            $display("FAIL exit_hold: valid=%0b value=%h, required 0 0000005a", exit_valid_o,
                     exit_value_o);
        end
        print_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) bus_req(1'b1, PRINT_A, 32'h30 + i, 4'hF, 0, w);
        fork
            bus_req(1'b1, EXIT_A, 32'd0, 4'hF, 40, w);
            begin
                step(3);
                #1;
                checks++;
                if (gnt_o !== 1'b0) begin
                    errors++;
                    $display("FAIL exit_wait: gnt=%0b with chars queued, required 0", gnt_o);
                end
                print_ready_i = 1'b1;
            end
        join
        #1;
        checks++;
        if (w < 0 || exit_valid_o !== 1'b1 || exit_value_o !== 32'd0 ||
            print_valid_o !== 1'b0 || exp_chars.size() != 0) begin
            errors++;
            $display("FAIL exit_drain: wait=%0d valid=%0b value=%h pv=%0b left=%0d, required 1 0 0 0",
                     w, exit_valid_o, exit_value_o, print_valid_o, exp_chars.size());
        end
        step(1);
        checks++;
        if (exit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL exit_once: valid=%0b, required 0", exit_valid_o);
        end
    endtask

    task automatic test_status;
        int w;
        bus_req(1'b1, STATUS_A, 32'd123456789, 4'hF, 2, w);
        #1;
        checks++;
        if (tests_passed_o !== 1'b1 || tests_failed_o !== 1'b0 || exit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL status_pass: p=%0b f=%0b e=%0b, required 1 0 0", tests_passed_o,
                     tests_failed_o, exit_valid_o);
        end
        step(1);
        bus_req(1'b1, STATUS_A, 32'd1, 4'hF, 2, w);
        #1;
        checks++;
        if (tests_passed_o !== 1'b0 || tests_failed_o !== 1'b1) begin
            errors++;
            $display("FAIL status_fail: p=%0b f=%0b, required 0 1", tests_passed_o,
                     tests_failed_o);
        end
        step(1);
        checks++;
        if (tests_passed_o !== 1'b0 || tests_failed_o !== 1'b0) begin
            errors++;
            $display("FAIL status_once: p=%0b f=%0b, required 0 0", tests_passed_o,
                     tests_failed_o);
        end
    endtask

    task automatic test_cycle_err;
        int w;
        bus_req(1'b0, CYCLE_A, 32'd0, 4'hF, 0, w);
        step(8);
        bus_req(1'b0, CYCLE_A, 32'd0, 4'hF, 0, w);
        bus_req(1'b1, CYCLE_A, 32'h1234, 4'hF, 0, w);
        bus_req(1'b0, 32'h3000_0000, 32'd0, 4'hF, 0, w);
        bus_req(1'b0, PRINT_A, 32'd0, 4'hF, 0, w);
        bus_req(1'b0, EXIT_A + 32'd2, 32'd0, 4'hF, 0, w);
        bus_req(1'b1, PRINT_A, 32'h55, 4'hE, 0, w);
        #1;
        checks++;
        if (w !== 0 || print_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL be0_write: wait=%0d pv=%0b, required 0 0", w, print_valid_o);
        end
        step(2);
        checks++;
        if (exp_resp.size() != 0) begin
            errors++;
            $display("FAIL resp_missing: %0d responses outstanding, required 0", exp_resp.size());
        end
    endtask

    task automatic test_reset_mid;
        int w;
        print_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) bus_req(1'b1, PRINT_A, 32'h61 + i, 4'hF, 0, w);
        req_i = 1'b1; we_i = 1'b1; addr_i = EXIT_A; wdata_i = 32'd9; be_i = 4'hF;
        #1;
        rst_ni = 1'b0;
        req_i = 1'b0;
        #1;
        exp_chars.delete();
        exp_resp.delete();
        checks++;
        if ({gnt_o, rvalid_o, rdata_o, err_o, print_valid_o, print_wdata_o, tests_passed_o,
             tests_failed_o, exit_valid_o} !== '0) begin
            errors++;
            $display("FAIL midreset_clear: rv=%0b pv=%0b e=%0b, required all 0", rvalid_o,
                     print_valid_o, exit_valid_o);
        end
        step(2);
        rst_ni = 1'b1;
        print_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            #1;
            checks++;
            if (print_valid_o !== 1'b0 || exit_valid_o !== 1'b0 || rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet: pv=%0b e=%0b rv=%0b, required 0 0 0",
                         print_valid_o, exit_valid_o, rvalid_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_print_burst();
        test_fifo_full();
        test_exit();
        test_status();
        test_cycle_err();
        test_reset_mid();
        step(2);
        checks++;
        if (exp_chars.size() != 0 || exp_resp.size() != 0) begin
            errors++;
            $display("FAIL final_empty: %0d chars %0d resps left, required 0",
                     exp_chars.size(), exp_resp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
